// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state types and constants for the mul/div sequencer
package muldiv_pkg;

  // Encodings shared with the decoder's aluop mapping
  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MUL   = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_t;

  localparam int DIV_ITERS = 32;

  function automatic logic is_mul_op(muldiv_op_t op);
    return !(op == OP_DIV || op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - E-stage handshake bundle between pipeline and mul/div sequencer
interface muldiv_if #(parameter int XLEN = 32);
  import muldiv_pkg::*;

  logic              start_i;
  muldiv_op_t        op_i;
  logic [XLEN-1:0]   a_i;
  logic [XLEN-1:0]   b_i;
  logic [2*XLEN-1:0] hilo_i;
  logic              flush_i;
  logic              ack_i;
  logic              stall_o;
  logic              done_o;
  logic [2*XLEN-1:0] result_o;
  logic              hilo_we_o;
  logic              gpr_we_o;

  modport master (
    output start_i, op_i, a_i, b_i, hilo_i, flush_i, ack_i,
    input  stall_o, done_o, result_o, hilo_we_o, gpr_we_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, hilo_i, flush_i, ack_i,
    output stall_o, done_o, result_o, hilo_we_o, gpr_we_o
  );
endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// rtl/muldiv_ctrl_div_iter.sv - restoring radix-2 divider core on unsigned magnitudes
module div_iter
  import muldiv_pkg::*;
#(
  parameter int W = DIV_ITERS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         busy_o,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q;
  logic [CW-1:0] cnt_q;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  function automatic logic [2*W-1:0] step(logic [W-1:0] rem, logic [W-1:0] quo,
                                          logic [W-1:0] dvs);
    logic [W:0] r;
    logic       bit_q;
    r     = {rem, quo[W-1]};
    bit_q = 1'b0;
    if (r >= {1'b0, dvs}) begin
      r     = r - {1'b0, dvs};
      bit_q = 1'b1;
    end
    return {r[W-1:0], quo[W-2:0], bit_q};
  endfunction

  // The first iteration runs on the start edge straight from the inputs
  always_comb begin
    {rem_d, quo_d} = step(rem_q, quo_q, dvs_q);
    if (start_i) {rem_d, quo_d} = step('0, dividend_i, divisor_i);
  end

  // Iteration state: load on start, then W-1 more steps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= divisor_i;
      cnt_q <= CW'(W - 1);
    end else if (cnt_q != '0) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign busy_o      = (cnt_q != '0);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - mul/div sequencer for E stage; DIV_ZERO_FAST_EN short-circuits divide by zero
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  muldiv_state_t     state_q, state_d;
  muldiv_op_t        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] result_q, result_d;

  logic              accept, done, div_start, div_busy;
  logic [XLEN-1:0]   a_mag, b_mag, div_quo, div_rem, q_fix, r_fix;
  logic [2*XLEN-1:0] div_result;

  function automatic logic [2*XLEN-1:0] mul_calc(muldiv_op_t op, logic [XLEN-1:0] a,
                                                 logic [XLEN-1:0] b, logic [2*XLEN-1:0] hilo);
    logic [2*XLEN-1:0] ps, pu, p;
    ps = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
    pu = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    p  = (op == OP_MULTU || op == OP_MADDU || op == OP_MSUBU) ? pu : ps;
    case (op)
      OP_MADD, OP_MADDU: return hilo + p;
      OP_MSUB, OP_MSUBU: return hilo - p;
      OP_MUL:            return {{XLEN{1'b0}}, p[XLEN-1:0]};
      default:           return p;
    endcase
  endfunction

  assign accept    = bus.start_i & ~bus.flush_i;
  assign div_start = (state_q == S_IDLE) & accept & ~is_mul_op(bus.op_i);
  assign a_mag     = (bus.op_i == OP_DIV && bus.a_i[XLEN-1]) ? -bus.a_i : bus.a_i;
  assign b_mag     = (bus.op_i == OP_DIV && bus.b_i[XLEN-1]) ? -bus.b_i : bus.b_i;

  div_iter #(.W(XLEN)) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .busy_o      (div_busy),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Sign fix: quotient truncates toward zero, remainder follows the dividend
  always_comb begin
    q_fix = div_quo;
    r_fix = div_rem;
    if (op_q == OP_DIV && (a_q[XLEN-1] ^ b_q[XLEN-1])) q_fix = -div_quo;
    if (op_q == OP_DIV && a_q[XLEN-1])                 r_fix = -div_rem;
    div_result = (b_q == '0) ? {a_q, {XLEN{1'b1}}} : {r_fix, q_fix};
  end

  // Next-state: accept in IDLE, count the multiplier, wait for the divider, hold in DONE
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = bus.op_i;
          a_d   = bus.a_i;
          b_d   = bus.b_i;
          cnt_d = 3'd1;
          if (is_mul_op(bus.op_i)) begin
            result_d = mul_calc(bus.op_i, bus.a_i, bus.b_i, bus.hilo_i);
            state_d  = (MUL_LAT == 1) ? S_DONE : S_MUL;
          end else begin
`ifdef DIV_ZERO_FAST_EN
            if (bus.b_i == '0) begin
              result_d = {bus.a_i, {XLEN{1'b1}}};
              state_d  = S_DONE;
            end else begin
              state_d = S_DIV;
            end
`else
            state_d = S_DIV;
`endif
          end
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(MUL_LAT - 1)) state_d = S_DONE;
      end
      S_DIV: begin
        if (!div_busy) begin
          result_d = div_result;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush_i) state_d = S_IDLE;
  end

  // State and operand registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign done          = (state_q == S_DONE);
  assign bus.done_o    = done;
  assign bus.stall_o   = ((state_q == S_IDLE) & bus.start_i) | (state_q == S_MUL) |
                         (state_q == S_DIV);
  assign bus.result_o  = result_q;
  assign bus.hilo_we_o = done & bus.ack_i & ~bus.flush_i & (op_q != OP_MUL);
  assign bus.gpr_we_o  = done & bus.ack_i & ~bus.flush_i & (op_q == OP_MUL);
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed scoreboard bench for muldiv_ctrl
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_ctrl #(.XLEN(32), .MUL_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];
  logic        sb_gpr_q[$];

`ifdef DIV_ZERO_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(muldiv_op_t op, logic [31:0] a, logic [31:0] b,
                                        logic [63:0] hilo);
    longint          sa, sb;
    longint unsigned ua, ub, ps, pu;
    int              sa32, sb32, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = sa * sb;
    ua = {32'b0, a};
    ub = {32'b0, b};
    pu = ua * ub;
    case (op)
      OP_MULT:  return ps;
      OP_MULTU: return pu;
      OP_MUL:   return {32'b0, ps[31:0]};
      OP_MADD:  return hilo + ps;
      OP_MADDU: return hilo + pu;
      OP_MSUB:  return hilo - ps;
      OP_MSUBU: return hilo - pu;
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        sa32 = a;
        sb32 = b;
        q = sa32 / sb32;
        r = sa32 % sb32;
        return {r, q};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] hilo, input int lat, input int hold);
    int          cyc;
    logic        stall_bad;
    logic [63:0] exp_r;
    logic        exp_gpr;
    sb_q.push_back(model(op, a, b, hilo));
    sb_gpr_q.push_back(op == OP_MUL);
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.hilo_i  = hilo;
    cyc = 0;
    stall_bad = 1'b0;
    @(negedge clk);
    while (!bus.done_o && cyc < 100) begin
      if (bus.stall_o !== 1'b1) stall_bad = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      bus.a_i     = $urandom;
      bus.b_i     = $urandom;
      cyc++;
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    exp_r   = sb_q.pop_front();
    exp_gpr = sb_gpr_q.pop_front();
    check("stall_while_busy", {63'b0, stall_bad}, 64'd0);
    check("latency", 64'(cyc), 64'(lat));
    check("stall_in_done", {63'b0, bus.stall_o}, 64'd0);
    check("result", bus.result_o, exp_r);
    repeat (hold) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("done_held", {63'b0, bus.done_o}, 64'd1);
      check("result_held", bus.result_o, exp_r);
      check("no_we_before_ack", {62'b0, bus.hilo_we_o, bus.gpr_we_o}, 64'd0);
    end
    @(posedge clk); #1;
    bus.ack_i = 1'b1;
    @(negedge clk);
    check("hilo_we", {63'b0, bus.hilo_we_o}, {63'b0, ~exp_gpr});
    check("gpr_we", {63'b0, bus.gpr_we_o}, {63'b0, exp_gpr});
    @(posedge clk); #1;
    bus.ack_i = 1'b0;
    @(negedge clk);
    check("done_after_ack", {63'b0, bus.done_o}, 64'd0);
  endtask

  initial begin
    int         cyc;
    muldiv_op_t rop;
    logic [31:0] ra, rb;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = OP_MULT;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.hilo_i  = '0;
    bus.flush_i = 1'b0;
    bus.ack_i   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {63'b0, bus.stall_o}, 64'd0);
    check("rst_done", {63'b0, bus.done_o}, 64'd0);
    check("rst_hilo_we", {63'b0, bus.hilo_we_o}, 64'd0);
    check("rst_gpr_we", {63'b0, bus.gpr_we_o}, 64'd0);
    check("rst_result", bus.result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Spec vectors
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, 64'd0, 2, 0);
    check("mult_const", model(OP_MULT, 32'hFFFFFFFD, 32'd5, 64'd0), 64'hFFFFFFFF_FFFFFFF1);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 64'd0, 33, 0);
    run_op(OP_DIVU, 32'd7, 32'd0, 64'd0, DZ_LAT, 0);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd0, 64'd0, DZ_LAT, 0);
    run_op(OP_MADDU, 32'd1, 32'd1, 64'h00000001_FFFFFFFF, 2, 0);
    run_op(OP_MSUB, 32'd1, 32'd1, 64'd0, 2, 0);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 2, 3);
    run_op(OP_DIVU, 32'd100, 32'd7, 64'd0, 33, 3);

    // Flush during a divide, then back-to-back MUL
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.op_i    = OP_DIV;
    bus.a_i     = 32'd100;
    bus.b_i     = 32'd3;
    repeat (10) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0;
    end
    bus.flush_i = 1'b1;
    @(negedge clk);
    check("flush_no_we", {62'b0, bus.hilo_we_o, bus.gpr_we_o}, 64'd0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_stall_low", {63'b0, bus.stall_o}, 64'd0);
    check("flush_done_low", {63'b0, bus.done_o}, 64'd0);
    run_op(OP_MUL, 32'd6, 32'd7, 64'd0, 2, 0);
    check("mul_const", model(OP_MUL, 32'd6, 32'd7, 64'd0), 64'd42);

    // Flush together with ack in DONE
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.op_i    = OP_MULT;
    bus.a_i     = 32'd2;
    bus.b_i     = 32'd3;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    cyc = 1;
    while (!bus.done_o && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("flush_ack_reached_done", {63'b0, bus.done_o}, 64'd1);
    bus.ack_i   = 1'b1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    check("flush_ack_no_we", {62'b0, bus.hilo_we_o, bus.gpr_we_o}, 64'd0);
    @(posedge clk); #1;
    bus.ack_i   = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_ack_idle", {63'b0, bus.done_o}, 64'd0);

    // Flush together with start: the start is dropped
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.op_i    = OP_MULT;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_start_ignored", {63'b0, bus.stall_o}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_start_no_done", {63'b0, bus.done_o}, 64'd0);

    // Random mix through the scoreboard
    for (int i = 0; i < 8; i++) begin
      rop = muldiv_op_t'($urandom_range(0, 8));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 3 == 0) rb = $urandom_range(1, 20);
      if (rb == 32'd0) rb = 32'd1;
      if (rop == OP_DIV && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
      run_op(rop, ra, rb, {$urandom, $urandom}, is_mul_op(rop) ? 2 : 33, i % 2);
    end

    // Reset mid-operation
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.op_i    = OP_DIV;
    bus.a_i     = 32'd50;
    bus.b_i     = 32'd5;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midop_rst_stall", {63'b0, bus.stall_o}, 64'd0);
    check("midop_rst_done", {63'b0, bus.done_o}, 64'd0);
    check("midop_rst_result", bus.result_o, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
